// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads words sequentially and hands them to the decoder over a four-phase DOR/ack handshake.
// Build option IFETCH_PREFETCH_EN inserts a 2-entry prefetch FIFO so memory reads overlap the decoder handshake.
module instruction_fetch #(
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
  parameter logic [15:0] MAX_FETCH = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] start_pc,
  input  logic        stop,
  output logic        busy,
  output logic        done,
  output logic [15:0] pc_out,
  output logic [15:0] fetch_count,
  output logic        DOR,
  output logic [31:0] data_out,
  input  logic        ack_from_next,
  output logic [9:0]  mem_addr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_do,
  input  logic        mem_do_ack
);

  typedef enum logic [2:0] {
    IDLE, FETCH_REQ, FETCH_WAIT, PRESENT, WAIT_ACK_LOW, STREAM, END
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] fetchCount_q, fetchCount_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dor_q, dor_d;
  logic [31:0] dataOut_q, dataOut_d;
  logic [9:0]  memAddr_q, memAddr_d;
  logic        memEn_q, memEn_d;
  logic        stopSeen_q, stopSeen_d;
  logic        stopNow;

  // A stop arriving in the same cycle as a decision point counts as already seen.
  assign stopNow = stopSeen_q | stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      fetchCount_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dor_q        <= 1'b0;
      dataOut_q    <= '0;
      memAddr_q    <= '0;
      memEn_q      <= 1'b0;
      stopSeen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetchCount_q <= fetchCount_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dor_q        <= dor_d;
      dataOut_q    <= dataOut_d;
      memAddr_q    <= memAddr_d;
      memEn_q      <= memEn_d;
      stopSeen_q   <= stopSeen_d;
    end
  end

`ifdef IFETCH_PREFETCH_EN
  logic [31:0] fifo_q [2];
  logic [31:0] fifo_d [2];
  logic [1:0]  fifoCnt_q, fifoCnt_d;
  logic        rdPtr_q, rdPtr_d;
  logic        wrPtr_q, wrPtr_d;
  logic        waitLow_q, waitLow_d;
  logic        halt_q, halt_d;
  logic [15:0] issued_q, issued_d;
  logic        push, pop, ending;

  assign ending = halt_q | stopNow | ((MAX_FETCH != 16'd0) && (issued_q == MAX_FETCH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      fifoCnt_q <= '0;
      rdPtr_q   <= 1'b0;
      wrPtr_q   <= 1'b0;
      waitLow_q <= 1'b0;
      halt_q    <= 1'b0;
      issued_q  <= '0;
    end else begin
      fifo_q    <= fifo_d;
      fifoCnt_q <= fifoCnt_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      waitLow_q <= waitLow_d;
      halt_q    <= halt_d;
      issued_q  <= issued_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetchCount_d = fetchCount_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    dor_d        = dor_q;
    dataOut_d    = dataOut_q;
    memAddr_d    = memAddr_q;
    memEn_d      = memEn_q;
    stopSeen_d   = stopSeen_q;
    fifo_d       = fifo_q;
    fifoCnt_d    = fifoCnt_q;
    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    waitLow_d    = waitLow_q;
    halt_d       = halt_q;
    issued_d     = issued_q;
    push         = 1'b0;
    pop          = 1'b0;
    if (state_q != IDLE && stop) stopSeen_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d         = start_pc & 16'hFFFC;
          fetchCount_d = '0;
          busy_d       = 1'b1;
          stopSeen_d   = stop;
          fifoCnt_d    = '0;
          rdPtr_d      = 1'b0;
          wrPtr_d      = 1'b0;
          waitLow_d    = 1'b0;
          halt_d       = 1'b0;
          issued_d     = '0;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (memEn_q) begin
          if (mem_do_ack) begin
            memEn_d   = 1'b0;
            memAddr_d = '0;
            if (!stopNow) begin
              if (mem_do == HALT_WORD) halt_d = 1'b1;
              else begin
                push = 1'b1;
                pc_d = pc_q + 16'd4;
              end
            end
          end
        end else if (!ending && fifoCnt_q != 2'd2) begin
          memEn_d   = 1'b1;
          memAddr_d = pc_q[11:2];
          issued_d  = issued_q + 16'd1;
        end
        // The presented word stays in the FIFO until acked, so it counts toward full.
        if (dor_q) begin
          if (ack_from_next) begin
            dor_d        = 1'b0;
            pop          = 1'b1;
            waitLow_d    = 1'b1;
            fetchCount_d = fetchCount_q + 16'd1;
          end
        end else if (waitLow_q) begin
          if (!ack_from_next) waitLow_d = 1'b0;
        end else if (fifoCnt_q != 2'd0 && !stopNow) begin
          dor_d     = 1'b1;
          dataOut_d = fifo_q[rdPtr_q];
        end
        if (push) begin
          fifo_d[wrPtr_q] = mem_do;
          wrPtr_d         = ~wrPtr_q;
        end
        if (pop) rdPtr_d = ~rdPtr_q;
        fifoCnt_d = fifoCnt_q + {1'b0, push} - {1'b0, pop};
        if (stopNow) begin
          if (dor_q && !pop) begin
            fifoCnt_d = 2'd1;
            wrPtr_d   = ~rdPtr_q;
          end else begin
            fifoCnt_d = 2'd0;
            wrPtr_d   = rdPtr_d;
          end
        end
        if (ending && !memEn_q && fifoCnt_q == 2'd0 && !dor_q && !waitLow_q) state_d = END;
      end
      END: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`else
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetchCount_d = fetchCount_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    dor_d        = dor_q;
    dataOut_d    = dataOut_q;
    memAddr_d    = memAddr_q;
    memEn_d      = memEn_q;
    stopSeen_d   = stopSeen_q;
    if (state_q != IDLE && stop) stopSeen_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d         = start_pc & 16'hFFFC;
          fetchCount_d = '0;
          busy_d       = 1'b1;
          stopSeen_d   = stop;
          state_d      = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        memAddr_d = pc_q[11:2];
        memEn_d   = 1'b1;
        state_d   = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (mem_do_ack) begin
          memEn_d   = 1'b0;
          memAddr_d = '0;
          if (stopNow || mem_do == HALT_WORD) state_d = END;
          else begin
            dataOut_d = mem_do;
            dor_d     = 1'b1;
            pc_d      = pc_q + 16'd4;
            state_d   = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (ack_from_next) begin
          dor_d        = 1'b0;
          fetchCount_d = fetchCount_q + 16'd1;
          state_d      = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        if (!ack_from_next) begin
          if (stopNow || ((MAX_FETCH != 16'd0) && (fetchCount_q == MAX_FETCH))) state_d = END;
          else state_d = FETCH_REQ;
        end
      end
      END: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign pc_out      = pc_q;
  assign fetch_count = fetchCount_q;
  assign DOR         = dor_q;
  assign data_out    = dataOut_q;
  assign mem_addr    = memAddr_q;
  assign mem_en      = memEn_q;
  assign mem_we      = 1'b0;
  assign mem_di      = '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected decoder words are queued at stimulus time and popped by monitors.
// A second instance built with MAX_FETCH=3 uses an always-ready memory and an echoing decoder.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [15:0] start_pc;
  logic        busy, done, DOR, mem_en, mem_we, mem_do_ack, ack_from_next;
  logic [15:0] pc_out, fetch_count;
  logic [31:0] data_out, mem_di, mem_do;
  logic [9:0]  mem_addr;

  logic        startLim, stopLim, busyLim, doneLim, dorLim, enLim, weLim, ackLim, memAckLim;
  logic [15:0] pcStartLim, pcLim, countLim;
  logic [31:0] dataLim, diLim, memDoLim;
  logic [9:0]  addrLim;

  logic [31:0] mem [0:1023];
  logic        memAuto, manualAck, autoAck;
  logic [31:0] autoDo;
  int          memLat, latCnt;
  int          checks = 0;
  int          errors = 0;
  int          ackDelay = 0;
  int          ackHold = 1;
  int          limReads = 0;
  logic [31:0] expQ[$];
  logic [31:0] limQ[$];
  logic [9:0]  addrLog[$];
  logic        prevEn = 1'b0;
  logic        prevEnLim = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .stop(stop),
    .busy(busy), .done(done), .pc_out(pc_out), .fetch_count(fetch_count),
    .DOR(DOR), .data_out(data_out), .ack_from_next(ack_from_next),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_di(mem_di),
    .mem_do(mem_do), .mem_do_ack(mem_do_ack)
  );

  instruction_fetch #(.MAX_FETCH(16'd3)) dutLim (
    .clk(clk), .reset(reset), .start(startLim), .start_pc(pcStartLim), .stop(stopLim),
    .busy(busyLim), .done(doneLim), .pc_out(pcLim), .fetch_count(countLim),
    .DOR(dorLim), .data_out(dataLim), .ack_from_next(ackLim),
    .mem_addr(addrLim), .mem_en(enLim), .mem_we(weLim), .mem_di(diLim),
    .mem_do(memDoLim), .mem_do_ack(memAckLim)
  );

  // Limited instance: memory answers in the request cycle, decoder acks whenever DOR is up.
  assign ackLim    = dorLim;
  assign memAckLim = enLim;
  assign memDoLim  = mem[addrLim];

  // Main instance memory: fixed latency responder, overridable by hand for the reset test.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      autoAck <= 1'b0;
      autoDo  <= '0;
      latCnt  <= 0;
    end else begin
      autoAck <= 1'b0;
      if (memAuto && mem_en && !autoAck) begin
        if (latCnt >= memLat) begin
          autoAck <= 1'b1;
          autoDo  <= mem[mem_addr];
          latCnt  <= 0;
        end else latCnt <= latCnt + 1;
      end else latCnt <= 0;
    end
  end
  assign mem_do_ack = memAuto ? autoAck : manualAck;
  assign mem_do     = memAuto ? autoDo : 32'h0BADF00D;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Decoder model: acks ackDelay cycles after DOR appears and holds ack for ackHold cycles.
  initial begin
    ack_from_next = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (DOR) begin
        repeat (ackDelay) @(posedge clk);
        #1 ack_from_next = 1'b1;
        repeat (ackHold) @(posedge clk);
        #1 ack_from_next = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (DOR && ack_from_next) begin
      checkOutput("wordExpected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) checkOutput("dataOut", data_out, expQ.pop_front());
    end else if (DOR && expQ.size() != 0) begin
      checkOutput("dataStable", data_out, expQ[0]);
    end
    if (DOR || ack_from_next) checkOutput("memEnInHandshake", {31'd0, mem_en}, 32'd0);
    if (mem_en && !prevEn) addrLog.push_back(mem_addr);
    prevEn <= mem_en;
  end

  always @(negedge clk) begin
    if (dorLim) begin
      checkOutput("limWordExpected", 32'(limQ.size() != 0), 32'd1);
      if (limQ.size() != 0) checkOutput("limDataOut", dataLim, limQ.pop_front());
    end
    if (enLim && !prevEnLim) limReads <= limReads + 1;
    prevEnLim <= enLim;
  end

  task automatic applyStimulus(input logic [15:0] pc, input logic withStop);
    addrLog.delete();
    @(posedge clk);
    #1;
    start_pc = pc;
    start    = 1'b1;
    stop     = withStop;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic waitDone(input string name, input bit lim, input int budget);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (lim ? doneLim : done) seen = 1'b1;
    end
    checkOutput({name, "Done"}, {31'd0, seen}, 32'd1);
    checkOutput({name, "BusyLow"}, {31'd0, lim ? busyLim : busy}, 32'd0);
    @(negedge clk);
    checkOutput({name, "DonePulse"}, {31'd0, lim ? doneLim : done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected run completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    reset = 1'b0; start = 1'b0; stop = 1'b0; start_pc = '0;
    startLim = 1'b0; stopLim = 1'b0; pcStartLim = '0;
    memAuto = 1'b1; manualAck = 1'b0; memLat = 2;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstDor", {31'd0, DOR}, 32'd0);
    checkOutput("rstMemEn", {31'd0, mem_en}, 32'd0);
    checkOutput("rstPc", {16'd0, pc_out}, 32'd0);
    checkOutput("rstCount", {16'd0, fetch_count}, 32'd0);
    checkOutput("rstData", data_out, 32'd0);
    checkOutput("rstMemAddr", {22'd0, mem_addr}, 32'd0);
    checkOutput("memWe", {31'd0, mem_we | weLim}, 32'd0);
    checkOutput("memDi", mem_di | diLim, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    $display("[TB] reset during FETCH_WAIT");
    memAuto = 1'b0;
    applyStimulus(16'h0040, 1'b0);
    n = 0;
    while (!mem_en && n < 10) begin @(negedge clk); n++; end
    checkOutput("midEnRaised", {31'd0, mem_en}, 32'd1);
    checkOutput("midPc", {16'd0, pc_out}, 32'h0040);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("asyncDor", {31'd0, DOR}, 32'd0);
    checkOutput("asyncMemEn", {31'd0, mem_en}, 32'd0);
    checkOutput("asyncBusy", {31'd0, busy}, 32'd0);
    checkOutput("asyncDone", {31'd0, done}, 32'd0);
    checkOutput("asyncPc", {16'd0, pc_out}, 32'd0);
    checkOutput("asyncMemAddr", {22'd0, mem_addr}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    manualAck = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("lateAckIgnored", {29'd0, mem_en, busy, DOR}, 32'd0);
    end
    manualAck = 1'b0;
    memAuto   = 1'b1;

    $display("[TB] basic run");
    mem[0] = 32'h00851020; mem[1] = 32'h20A50001; mem[2] = 32'hFFFFFFFF;
    ackDelay = 0; ackHold = 1;
    expQ.push_back(32'h00851020);
    expQ.push_back(32'h20A50001);
    applyStimulus(16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("startLat1MemEn", {31'd0, mem_en}, 32'd0);
    checkOutput("startBusy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("startLat2MemEn", {31'd0, mem_en}, 32'd1);
    waitDone("basic", 1'b0, 200);
    checkOutput("basicPc", {16'd0, pc_out}, 32'h0008);
    checkOutput("basicCount", {16'd0, fetch_count}, 32'd2);
    checkOutput("basicDrained", expQ.size(), 32'd0);

    $display("[TB] slow consumer with ignored restart");
    mem[16] = 32'h11112222; mem[17] = 32'h33334444; mem[18] = 32'hFFFFFFFF;
    ackDelay = 5; ackHold = 3;
    expQ.push_back(32'h11112222);
    expQ.push_back(32'h33334444);
    applyStimulus(16'h0040, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start_pc = 16'h0200;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("slow", 1'b0, 300);
    checkOutput("slowPc", {16'd0, pc_out}, 32'h0048);
    checkOutput("slowCount", {16'd0, fetch_count}, 32'd2);
    checkOutput("slowReads", addrLog.size(), 32'd3);
    checkOutput("slowDrained", expQ.size(), 32'd0);

    $display("[TB] address wrap");
    mem[1023] = 32'h00000020; mem[0] = 32'hFFFFFFFF;
    ackDelay = 1; ackHold = 1;
    expQ.push_back(32'h00000020);
    applyStimulus(16'h0FFC, 1'b0);
    waitDone("wrap", 1'b0, 200);
    checkOutput("wrapReads", addrLog.size(), 32'd2);
    checkOutput("wrapAddr0", (addrLog.size() > 0) ? {22'd0, addrLog[0]} : 32'hDEAD, 32'd1023);
    checkOutput("wrapAddr1", (addrLog.size() > 1) ? {22'd0, addrLog[1]} : 32'hDEAD, 32'd0);
    checkOutput("wrapPc", {16'd0, pc_out}, 32'h1000);
    checkOutput("wrapCount", {16'd0, fetch_count}, 32'd1);
    checkOutput("wrapDrained", expQ.size(), 32'd0);

    $display("[TB] stop during PRESENT");
    mem[32] = 32'hAAAA5555; mem[33] = 32'h12345678; mem[34] = 32'hFFFFFFFF;
    ackDelay = 4; ackHold = 1;
    expQ.push_back(32'hAAAA5555);
    applyStimulus(16'h0080, 1'b0);
    n = 0;
    while (!DOR && n < 50) begin @(negedge clk); n++; end
    checkOutput("stopDorSeen", {31'd0, DOR}, 32'd1);
    @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    waitDone("stop", 1'b0, 200);
    checkOutput("stopCount", {16'd0, fetch_count}, 32'd1);
    checkOutput("stopPc", {16'd0, pc_out}, 32'h0084);
    checkOutput("stopReads", addrLog.size(), 32'd1);
    checkOutput("stopDrained", expQ.size(), 32'd0);

    $display("[TB] start and stop together");
    mem[48] = 32'hDEADBEEF;
    ackDelay = 0; ackHold = 1;
    applyStimulus(16'h00C0, 1'b1);
    waitDone("startStop", 1'b0, 200);
    checkOutput("startStopCount", {16'd0, fetch_count}, 32'd0);
    checkOutput("startStopPc", {16'd0, pc_out}, 32'h00C0);
    checkOutput("startStopReads", addrLog.size(), 32'd1);

    $display("[TB] MAX_FETCH=3 instance");
    for (int i = 0; i < 7; i++) mem[64 + i] = 32'h10000000 + i;
    for (int i = 0; i < 3; i++) limQ.push_back(32'h10000000 + i);
    @(posedge clk);
    #1;
    pcStartLim = 16'h0100;
    startLim   = 1'b1;
    @(posedge clk);
    #1 startLim = 1'b0;
    waitDone("limit", 1'b1, 200);
    checkOutput("limitCount", {16'd0, countLim}, 32'd3);
    checkOutput("limitPc", {16'd0, pcLim}, 32'h010C);
    checkOutput("limitReads", limReads, 32'd3);
    checkOutput("limitDrained", limQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
